// File: rtl/rr_arbiter_4.sv
// ============================================================================
//  Module   : rr_arbiter_4
//  Purpose  : Four-requester arbiter with registered one-hot grant, encoded
//             index, grant hold and hold-limit preemption. Defining
//             RR_ARB_ROTATE_EN selects rotating priority; otherwise fixed 3>2>1>0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int              c_HOLD_LIM_I = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
  localparam logic [HOLD_W-1:0] c_HOLD_LIM = c_HOLD_LIM_I[HOLD_W-1:0];
  localparam logic [HOLD_W-1:0] c_HOLD_ONE = 1;

  state_t              state_q, state_d;
  logic [1:0]          last_q, last_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [1:0]          gnt_idx_q, gnt_idx_d;
  logic                gnt_valid_q, gnt_valid_d;
  logic                preempt_q, preempt_d;

  logic [1:0]          w_base;
  logic [3:0]          w_others;
  logic [1:0]          w_win_all;
  logic [1:0]          w_win_oth;
  logic                w_owner_req;

  // Search order is base-1, base-2, base-3, base (mod 4); base 0 yields 3,2,1,0.
  function automatic logic [1:0] pick(input logic [3:0] m, input logic [1:0] base);
    logic [1:0] cand;
    pick = base;
    for (int off = 4; off >= 1; off--) begin
      cand = base - 2'(off);
      if (m[cand]) pick = cand;
    end
  endfunction

`ifdef RR_ARB_ROTATE_EN
  assign w_base = last_q;
`else
  assign w_base = 2'd0;
`endif

  assign w_owner_req = req[last_q];
  assign w_others    = req & ~(4'b0001 << last_q);
  assign w_win_all   = pick(req, w_base);
  assign w_win_oth   = pick(w_others, w_base);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    hold_d      = hold_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d     = ST_GRANT;
          last_d      = w_win_all;
          hold_d      = '0;
          gnt_d       = 4'b0001 << w_win_all;
          gnt_idx_d   = w_win_all;
          gnt_valid_d = 1'b1;
        end
      end

      ST_GRANT: begin
        if (!w_owner_req) begin
          // Owner released: hand over on the same edge, or fall back to idle.
          if (|req) begin
            last_d      = w_win_all;
            hold_d      = '0;
            gnt_d       = 4'b0001 << w_win_all;
            gnt_idx_d   = w_win_all;
            gnt_valid_d = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            hold_d      = '0;
            gnt_d       = 4'b0000;
            gnt_idx_d   = 2'd0;
            gnt_valid_d = 1'b0;
          end
        end else if (MAX_HOLD != 0 && hold_q == c_HOLD_LIM) begin
          // Hold limit reached: counter saturates until a competitor shows up.
          if (|w_others) begin
            last_d      = w_win_oth;
            hold_d      = '0;
            gnt_d       = 4'b0001 << w_win_oth;
            gnt_idx_d   = w_win_oth;
            gnt_valid_d = 1'b1;
            preempt_d   = 1'b1;
          end
        end else if (MAX_HOLD != 0) begin
          hold_d = hold_q + c_HOLD_ONE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        hold_d      = '0;
        gnt_d       = 4'b0000;
        gnt_idx_d   = 2'd0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 2'd0;
      hold_q      <= '0;
      gnt_q       <= 4'b0000;
      gnt_idx_q   <= 2'd0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
// ============================================================================
//  Module   : tb_rr_arbiter_4
//  Purpose  : Self-checking bench for rr_arbiter_4 (MAX_HOLD=4); expectations
//             follow RR_ARB_ROTATE_EN when it is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rr_arbiter_4;

  localparam int c_MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.MAX_HOLD(c_MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  // Reference model: owner, visible-cycle count and a priority list.
  bit         m_busy;
  int         m_owner, m_last, m_vis;
  logic [3:0] m_gnt;
  logic [1:0] m_idx;
  logic       m_pre;

  function automatic int winner(input logic [3:0] r, input int last);
    int order[4];
    for (int j = 0; j < 4; j++) begin
`ifdef RR_ARB_ROTATE_EN
      order[j] = (last - (j + 1) + 8) % 4;
`else
      order[j] = 3 - j;
`endif
    end
    for (int j = 0; j < 4; j++) if (r[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 0; m_vis = 0;
    m_gnt = 4'b0000; m_idx = 2'd0; m_pre = 1'b0;
  endtask

  task automatic model_grant(input int w);
    m_busy = 1; m_owner = w; m_last = w; m_vis = 1;
    m_gnt = 4'b0001 << w; m_idx = 2'(w);
  endtask

  task automatic model_edge(input logic [3:0] r);
    logic [3:0] others;
    m_pre = 1'b0;
    if (!m_busy) begin
      if (r != 0) model_grant(winner(r, m_last));
    end else if (!r[m_owner]) begin
      if (r != 0) model_grant(winner(r, m_last));
      else begin m_busy = 0; m_gnt = 4'b0000; m_idx = 2'd0; end
    end else if (c_MAX_HOLD == 0 || m_vis < c_MAX_HOLD) begin
      m_vis++;
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (others != 0) begin
        model_grant(winner(others, m_last));
        m_pre = 1'b1;
      end
    end
  endtask

  function automatic logic [7:0] model_out();
    return {m_gnt, m_idx, |m_gnt, m_pre};
  endfunction

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {gnt, gnt_idx, gnt_valid, preempt};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got gnt=%b idx=%b valid=%b pre=%b, expected gnt=%b idx=%b valid=%b pre=%b",
               name, $time, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic cycle(input logic [3:0] r, input logic rn);
    req   = r;
    rst_n = rn;
    @(posedge clk);
    if (!rn) model_reset();
    else     model_edge(r);
    #1;
  endtask

  typedef struct {
    logic       rn;
    logic [3:0] r;
    logic [3:0] g;
    logic [1:0] i;
    logic       v;
    logic       p;
  } vec_t;

  vec_t tbl[11];
  int   exp_a[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    logic       rn;

    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();

    tbl[0]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 4'b0111, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

    for (int k = 0; k < 11; k++) begin
      cycle(tbl[k].r, tbl[k].rn);
      check($sformatf("table[%0d]", k), {tbl[k].g, tbl[k].i, tbl[k].v, tbl[k].p});
    end

    // Back-to-back release: each owner drops its bit right after its grant.
`ifdef RR_ARB_ROTATE_EN
    exp_a = '{3, 2, 1, 0, 3};
`else
    exp_a = '{3, 2, 3, 2, 3};
`endif
    cycle(4'b0000, 1'b0);
    cycle(4'b1111, 1'b1);
    check("b2b[0]", {4'b0001 << exp_a[0], 2'(exp_a[0]), 1'b1, 1'b0});
    for (int k = 1; k < 5; k++) begin
      cycle(4'b1111 & ~(4'b0001 << exp_a[k-1]), 1'b1);
      check($sformatf("b2b[%0d]", k), {4'b0001 << exp_a[k], 2'(exp_a[k]), 1'b1, 1'b0});
    end

    // req=0101 from reset state, then owner releases.
    cycle(4'b0000, 1'b0);
    cycle(4'b0101, 1'b1);
`ifndef RR_ARB_ROTATE_EN
    check("fixed_0101", {4'b0100, 2'd2, 1'b1, 1'b0});
`endif
    check("seq_0101_a", model_out());
    cycle(4'b0001, 1'b1);
    check("seq_0101_b", model_out());
    cycle(4'b0101, 1'b1);
    check("seq_0101_c", model_out());

    // Preemption with two steady requesters.
    cycle(4'b0000, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      cycle(4'b1001, 1'b1);
      if (k <= 4)      check($sformatf("preempt[%0d]", k), {4'b1000, 2'd3, 1'b1, 1'b0});
      else if (k == 5) check("preempt[5]", {4'b0001, 2'd0, 1'b1, 1'b1});
      else if (k <= 8) check($sformatf("preempt[%0d]", k), {4'b0001, 2'd0, 1'b1, 1'b0});
      else             check("preempt[9]", {4'b1000, 2'd3, 1'b1, 1'b1});
    end

    // Hold expiry with no competitor, then a late competitor.
    cycle(4'b0000, 1'b0);
    for (int k = 0; k < 8; k++) cycle(4'b0010, 1'b1);
    check("expiry_hold", {4'b0010, 2'd1, 1'b1, 1'b0});
    cycle(4'b0011, 1'b1);
    check("expiry_preempt", {4'b0001, 2'd0, 1'b1, 1'b1});
    cycle(4'b0011, 1'b1);
    check("expiry_after", {4'b0001, 2'd0, 1'b1, 1'b0});

    // Reset asserted mid-grant clears outputs without a clock edge.
    cycle(4'b0000, 1'b0);
    cycle(4'b0100, 1'b1);
    cycle(4'b0100, 1'b1);
    check("pre_reset", {4'b0100, 2'd2, 1'b1, 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 8'b0);
    model_reset();
    @(posedge clk);
    #1;
    cycle(4'b1111, 1'b1);
    check("post_reset", {4'b1000, 2'd3, 1'b1, 1'b0});

    // Randomized traffic against the model.
    r = 4'b1111;
    for (int k = 0; k < 500; k++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      rn = ($urandom_range(0, 79) != 0);
      cycle(r, rn);
      check("random", model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
